// File: rtl/dut_commit_log_collector_pkg.sv
// Shared constants and types for the DUT-side commit log collector.
package dut_commit_log_collector_pkg;

  localparam int XREG_W           = 64;
  localparam int FREG_W           = 64;
  localparam int REG_KEY_TYPE_W   = 4;
  localparam int REG_KEY_ID_W     = XREG_W - REG_KEY_TYPE_W;
  localparam int CommitLogEntries = 16;
  localparam int CntW             = $clog2(CommitLogEntries + 1);
  localparam int IdxW             = $clog2(CommitLogEntries);

  typedef enum logic [REG_KEY_TYPE_W-1:0] {
    REG_XREG = 4'h0,
    REG_FREG = 4'h1,
    REG_VREG = 4'h2,
    REG_CSR  = 4'h4
  } reg_type_e;

  typedef struct packed {
    logic [REG_KEY_ID_W-1:0]   reg_id;
    logic [REG_KEY_TYPE_W-1:0] reg_type;
  } reg_key_t;

  typedef struct packed {
    reg_key_t          key;
    logic [FREG_W-1:0] value;
  } commit_log_reg_item_t;

  typedef struct packed {
    logic [CntW-1:0]                                count;
    commit_log_reg_item_t [CommitLogEntries-1:0]    items;
  } commit_log_batch_t;

  typedef enum logic { CB_COLLECT, CB_PENDING } cb_state_e;
  typedef enum logic { PB_IDLE, PB_VALID } pb_state_e;

  // Build a key from register id and type.
  function automatic reg_key_t mk_key(input logic [REG_KEY_ID_W-1:0] id,
                                      input logic [REG_KEY_TYPE_W-1:0] kind);
    reg_key_t k;
    k.reg_id   = id;
    k.reg_type = kind;
    return k;
  endfunction

endpackage

// File: rtl/dut_commit_log_collector_if.sv
// Core/checker-facing bundle of the commit log collector.
interface dut_commit_log_collector_if;
  import dut_commit_log_collector_pkg::*;

  logic                                        wr_valid;
  reg_key_t                                    wr_key;
  logic [FREG_W-1:0]                           wr_value;
  logic                                        retire;
  logic                                        stall;
  logic                                        log_valid;
  logic                                        log_ready;
  logic [CntW-1:0]                             log_count;
  commit_log_reg_item_t [CommitLogEntries-1:0] log_items;
  logic                                        overflow;
  logic                                        proto_err;

  // Driver side: core write events, retire and checker ready.
  modport master (
    output wr_valid, wr_key, wr_value, retire, log_ready,
    input  stall, log_valid, log_count, log_items, overflow, proto_err
  );

  // Collector side.
  modport slave (
    input  wr_valid, wr_key, wr_value, retire, log_ready,
    output stall, log_valid, log_count, log_items, overflow, proto_err
  );
endinterface

// File: rtl/dut_commit_log_collector_group_cam.sv
// Per-instruction write group: key CAM with overwrite-on-hit and append-on-miss.
// Exposes the next-state contents so a same-cycle write joins a closing group.
module commit_log_group_cam
  import dut_commit_log_collector_pkg::*;
(
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        we,
  input  reg_key_t                                    key,
  input  logic [FREG_W-1:0]                           value,
  input  logic                                        clr,
  output commit_log_reg_item_t [CommitLogEntries-1:0] items_next,
  output logic [CntW-1:0]                             count_next,
  output logic                                        drop
);

  commit_log_reg_item_t [CommitLogEntries-1:0] items_reg;
  logic [CntW-1:0]                             count_reg;
  logic [CommitLogEntries-1:0]                 hit_vec;
  logic                                        hit;
  logic [IdxW-1:0]                             hit_idx;

  // Only entries below the fill count take part in the match.
  generate
    for (genvar gi = 0; gi < CommitLogEntries; gi++) begin : g_match
      assign hit_vec[gi] = (CntW'(gi) < count_reg) && (items_reg[gi].key == key);
    end
  endgenerate

  // Resolve the hit index and compute the group contents after this write.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    items_next = items_reg;
    count_next = count_reg;
    drop       = 1'b0;
    for (int i = CommitLogEntries - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit     = 1'b1;
        hit_idx = i[IdxW-1:0];
      end
    end
    if (we) begin
      if (hit) begin
        items_next[hit_idx].value = value;
      end else if (count_reg == CntW'(CommitLogEntries)) begin
        drop = 1'b1;
      end else begin
        items_next[count_reg[IdxW-1:0]].key   = key;
        items_next[count_reg[IdxW-1:0]].value = value;
        count_next = count_reg + CntW'(1);
      end
    end
  end

  // Commit the group, or empty it when it has been handed to the present bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      items_reg <= '0;
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else begin
      items_reg <= items_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/dut_commit_log_collector.sv
// Commit log collector: groups register writes per retired instruction and
// presents each group as one batch through a valid/ready handshake.
module dut_commit_log_collector
  import dut_commit_log_collector_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  dut_commit_log_collector_if.slave bus
);

  cb_state_e                                   cb_state_reg;
  pb_state_e                                   pb_state_reg;
  commit_log_batch_t                           pb_reg;
  logic                                        overflow_reg;
  logic                                        proto_err_reg;
  logic                                        stall;
  logic                                        pb_free;
  logic                                        retire_ok;
  logic                                        move;
  logic                                        cam_drop;
  commit_log_reg_item_t [CommitLogEntries-1:0] cb_items_next;
  logic [CntW-1:0]                             cb_count_next;

  // The pending state is itself a register, so stall is registered too.
  assign stall     = (cb_state_reg == CB_PENDING);
  assign pb_free   = (pb_state_reg == PB_IDLE) || bus.log_ready;
  assign retire_ok = bus.retire && !stall;
  assign move      = pb_free && ((cb_state_reg == CB_COLLECT && retire_ok) ||
                                 (cb_state_reg == CB_PENDING));

  commit_log_group_cam u_cb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we         (bus.wr_valid && !stall),
    .key        (bus.wr_key),
    .value      (bus.wr_value),
    .clr        (move),
    .items_next (cb_items_next),
    .count_next (cb_count_next),
    .drop       (cam_drop)
  );

  // Collect/present bank FSMs, batch register and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cb_state_reg  <= CB_COLLECT;
      pb_state_reg  <= PB_IDLE;
      pb_reg        <= '0;
      overflow_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      case (cb_state_reg)
        CB_COLLECT: if (retire_ok && !pb_free) cb_state_reg <= CB_PENDING;
        CB_PENDING: if (pb_free) cb_state_reg <= CB_COLLECT;
      endcase
      if (move) begin
        pb_reg.count <= cb_count_next;
        pb_reg.items <= cb_items_next;
        pb_state_reg <= PB_VALID;
      end else if (pb_state_reg == PB_VALID && bus.log_ready) begin
        pb_state_reg <= PB_IDLE;
      end
      if (cam_drop) overflow_reg <= 1'b1;
      if (stall && (bus.wr_valid || bus.retire)) proto_err_reg <= 1'b1;
    end
  end

  assign bus.stall     = stall;
  assign bus.log_valid = (pb_state_reg == PB_VALID);
  assign bus.log_count = pb_reg.count;
  assign bus.log_items = pb_reg.items;
  assign bus.overflow  = overflow_reg;
  assign bus.proto_err = proto_err_reg;

endmodule
